// File: rtl/seq_divider_8bit.sv
// Sequential restoring divider: one quotient bit per clock, results held for the display.
// Define DIV_DONE_HOLD_EN to make done sticky until the next accepted start.
module seq_divider_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clock_100Mhz,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH:0]   a_reg, a_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] d_reg, d_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] quotient_reg, quotient_next;
    logic [WIDTH-1:0] remainder_reg, remainder_next;
    logic             dbz_reg, dbz_next;
    logic [WIDTH+1:0] a_wide;
    logic [WIDTH+1:0] diff;
`ifdef DIV_DONE_HOLD_EN
    logic             done_hold_reg, done_hold_next;
`endif

    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            q_reg         <= '0;
            d_reg         <= '0;
            cnt_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
`ifdef DIV_DONE_HOLD_EN
            done_hold_reg <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            a_reg         <= a_next;
            q_reg         <= q_next;
            d_reg         <= d_next;
            cnt_reg       <= cnt_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            dbz_reg       <= dbz_next;
`ifdef DIV_DONE_HOLD_EN
            done_hold_reg <= done_hold_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        a_next         = a_reg;
        q_next         = q_reg;
        d_next         = d_reg;
        cnt_next       = cnt_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        dbz_next       = dbz_reg;
`ifdef DIV_DONE_HOLD_EN
        done_hold_next = done_hold_reg;
`endif
        // {A,Q} shifted left by one; A never exceeds D, so the extra top bit stays 0.
        a_wide = {a_reg, q_reg[WIDTH-1]};
        diff   = a_wide - {2'b00, d_reg};

        case (state_reg)
            IDLE: begin
                if (start) begin
`ifdef DIV_DONE_HOLD_EN
                    done_hold_next = 1'b0;
`endif
                    if (divisor != '0) begin
                        q_next     = dividend;
                        d_next     = divisor;
                        a_next     = '0;
                        cnt_next   = '0;
                        state_next = CALC;
                    end else begin
                        quotient_next  = '1;
                        remainder_next = dividend;
                        dbz_next       = 1'b1;
                        state_next     = DONE;
`ifdef DIV_DONE_HOLD_EN
                        done_hold_next = 1'b1;
`endif
                    end
                end
            end
            CALC: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (!diff[WIDTH+1]) begin
                    a_next = diff[WIDTH:0];
                    q_next = {q_reg[WIDTH-2:0], 1'b1};
                end else begin
                    a_next = a_wide[WIDTH:0];
                    q_next = {q_reg[WIDTH-2:0], 1'b0};
                end
                // Outputs only move on the final step so the display never sees partial results.
                if (cnt_reg == LAST_STEP) begin
                    quotient_next  = q_next;
                    remainder_next = a_next[WIDTH-1:0];
                    dbz_next       = 1'b0;
                    state_next     = DONE;
`ifdef DIV_DONE_HOLD_EN
                    done_hold_next = 1'b1;
`endif
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;
    assign busy        = (state_reg == CALC);
`ifdef DIV_DONE_HOLD_EN
    assign done        = done_hold_reg;
`else
    assign done        = (state_reg == DONE);
`endif

endmodule

// File: tb/tb_seq_divider_8bit.sv
// Bench for seq_divider_8bit: arithmetic model checked every cycle plus directed literal checks.
module tb_seq_divider_8bit;

    logic       clock_100Mhz = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    seq_divider_8bit #(.WIDTH(8)) dut (
        .clock_100Mhz(clock_100Mhz),
        .reset(reset),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .quotient(quotient),
        .remainder(remainder),
        .busy(busy),
        .done(done),
        .div_by_zero(div_by_zero)
    );

    always #5 clock_100Mhz = ~clock_100Mhz;

    int checks = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Model: phase 0 idle, 1 computing, 2 reporting; results from plain / and %.
    int m_phase = 0;
    int m_left = 0;
    int m_q = 0, m_r = 0, m_z = 0, m_hold = 0;
    int m_pq = 0, m_pr = 0;

    always @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            m_phase <= 0; m_left <= 0; m_q <= 0; m_r <= 0; m_z <= 0; m_hold <= 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    if (divisor == 0) begin
                        m_q <= 255; m_r <= int'(dividend); m_z <= 1;
                        m_phase <= 2; m_hold <= 1;
                    end else begin
                        m_pq <= int'(dividend) / int'(divisor);
                        m_pr <= int'(dividend) % int'(divisor);
                        m_left <= 8; m_phase <= 1; m_hold <= 0;
                    end
                end
                1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_q <= m_pq; m_r <= m_pr; m_z <= 0;
                        m_phase <= 2; m_hold <= 1;
                    end
                end
                default: m_phase <= 0;
            endcase
        end
    end

    function automatic int exp_done();
`ifdef DIV_DONE_HOLD_EN
        return m_hold;
`else
        return (m_phase == 2) ? 1 : 0;
`endif
    endfunction

    always @(negedge clock_100Mhz) begin
        if (cmp_en) begin
            check("model quotient", int'(quotient), m_q);
            check("model remainder", int'(remainder), m_r);
            check("model div_by_zero", int'(div_by_zero), m_z);
            check("model busy", int'(busy), (m_phase == 1) ? 1 : 0);
            check("model done", int'(done), exp_done());
            check("busy_done_exclusive", int'(busy & done), 0);
        end
    end

    // Launch one operation; returns the cycle (1 = first after accept) where done was seen.
    task automatic run_op(input int dd, input int dv, output int lat, output int busy_cycles);
        @(negedge clock_100Mhz);
        start = 1'b1; dividend = 8'(dd); divisor = 8'(dv);
        lat = -1; busy_cycles = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock_100Mhz);
            if (k == 1) start = 1'b0;
            if (busy) busy_cycles++;
            if (done) begin lat = k; break; end
        end
        if (lat < 0) check("done_timeout", lat, 0);
    endtask

    int lat, bc, rises;
    logic prev_done;
    int tbl_dd [3] = '{255, 5, 255};
    int tbl_dv [3] = '{1, 10, 255};
    int tbl_q  [3] = '{255, 0, 1};
    int tbl_r  [3] = '{0, 5, 0};

    initial begin
        #2 reset = 1'b0;
        #1;
        check("reset quotient", int'(quotient), 0);
        check("reset remainder", int'(remainder), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset div_by_zero", int'(div_by_zero), 0);
        cmp_en = 1'b1;
        repeat (3) @(negedge clock_100Mhz);
        reset = 1'b1;
        repeat (3) @(negedge clock_100Mhz);
        check("post-reset busy", int'(busy), 0);
        check("post-reset done", int'(done), 0);

        run_op(200, 7, lat, bc);
        check("200/7 latency", lat, 9);
        check("200/7 busy cycles", bc, 8);
        check("200/7 quotient", int'(quotient), 28);
        check("200/7 remainder", int'(remainder), 4);
        check("200/7 div_by_zero", int'(div_by_zero), 0);

        for (int i = 0; i < 3; i++) begin
            run_op(tbl_dd[i], tbl_dv[i], lat, bc);
            $display("op %0d/%0d -> q=%0d r=%0d lat=%0d", tbl_dd[i], tbl_dv[i], quotient, remainder, lat);
            check("boundary latency", lat, 9);
            check("boundary quotient", int'(quotient), tbl_q[i]);
            check("boundary remainder", int'(remainder), tbl_r[i]);
        end

        run_op(8'h5A, 0, lat, bc);
        check("div0 latency", lat, 1);
        check("div0 quotient", int'(quotient), 255);
        check("div0 remainder", int'(remainder), 90);
        check("div0 flag", int'(div_by_zero), 1);
        run_op(12, 4, lat, bc);
        check("12/4 quotient", int'(quotient), 3);
        check("12/4 remainder", int'(remainder), 0);
        check("12/4 flag", int'(div_by_zero), 0);

        // Second start mid-computation and operand churn must not disturb the result.
        @(negedge clock_100Mhz);
        start = 1'b1; dividend = 8'd100; divisor = 8'd3;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock_100Mhz);
            if (k == 1) start = 1'b0;
            if (k == 3) begin start = 1'b1; dividend = 8'd50; divisor = 8'd5; end
            if (k == 4) begin start = 1'b0; dividend = 8'hA5; divisor = 8'h00; end
            if (done) begin lat = k; break; end
        end
        $display("op 100/3 with interference -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
        check("interfere latency", lat, 9);
        check("interfere quotient", int'(quotient), 33);
        check("interfere remainder", int'(remainder), 1);
        prev_done = done; rises = 0;
        repeat (12) begin
            @(negedge clock_100Mhz);
            if (done && !prev_done) rises++;
            prev_done = done;
        end
        check("no second done", rises, 0);

        // Reset mid-computation aborts and clears results.
        @(negedge clock_100Mhz);
        start = 1'b1; dividend = 8'd200; divisor = 8'd7;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock_100Mhz);
            if (k == 1) start = 1'b0;
        end
        #2 reset = 1'b0;
        #1;
        check("abort quotient", int'(quotient), 0);
        check("abort remainder", int'(remainder), 0);
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        @(negedge clock_100Mhz);
        reset = 1'b1;
        rises = 0;
        repeat (12) begin
            @(negedge clock_100Mhz);
            if (done) rises++;
        end
        check("no done after abort", rises, 0);
        $display("op 200/7 aborted by reset -> q=%0d r=%0d", quotient, remainder);

        // Done behaviour after completion, then cleared by the next accepted start.
        run_op(12, 4, lat, bc);
        repeat (5) @(negedge clock_100Mhz);
`ifdef DIV_DONE_HOLD_EN
        check("done held", int'(done), 1);
`else
        check("done held", int'(done), 0);
`endif
        run_op(9, 3, lat, bc);
        check("9/3 latency", lat, 9);
        check("9/3 quotient", int'(quotient), 3);
        $display("op 9/3 -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);

        repeat (2) @(negedge clock_100Mhz);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
